// File: rtl/led_pkg.sv
// Shared types and default panel constants for the LED frame writer.
package led_pkg;

  // Default panel geometry.
  localparam int unsigned N_LED   = 360;
  localparam int unsigned ROW_LEN = 24;

  // Output pattern selected per frame.
  typedef enum logic [1:0] {
    MODE_MAP    = 2'd0,
    MODE_FULL   = 2'd1,
    MODE_STRIPE = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_e;

  // Frame writer control states.
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/led_pattern_gen.sv
// Combinational data-word generator for one LED.
// Ports:
//   mode      - snapshotted pattern mode
//   k         - LED index being written
//   col       - column of k within its row (k mod ROW_LEN)
//   chase_pos - lit LED index for chase mode
//   pix       - snapshotted brightness pixel for k
//   gain      - snapshotted map gain
//   word_c    - resulting LED word (combinational)
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned AW      = 9,
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned GAIN_W  = 8,
  parameter int unsigned ROW_LEN = led_pkg::ROW_LEN,
  parameter int unsigned CW      = $clog2(ROW_LEN),
  parameter int unsigned DAT_W   = PIX_W + GAIN_W
) (
  input  mode_e              mode,
  input  logic [AW-1:0]      k,
  input  logic [CW-1:0]      col,
  input  logic [AW-1:0]      chase_pos,
  input  logic [PIX_W-1:0]   pix,
  input  logic [GAIN_W-1:0]  gain,
  output logic [DAT_W-1:0]   word_c
);

  localparam logic [CW-1:0] COL_T1 = CW'(ROW_LEN / 3);
  localparam logic [CW-1:0] COL_T2 = CW'((2 * ROW_LEN) / 3);

  // Word selection per mode; map product is kept at full width.
  always_comb begin
    word_c = '0;
    case (mode)
      MODE_MAP:    word_c = DAT_W'(pix) * DAT_W'(gain);
      MODE_FULL:   word_c = '1;
      MODE_STRIPE: begin
        if (col < COL_T1)      word_c = '1;
        else if (col < COL_T2) word_c = DAT_W'(1) << (DAT_W / 2);
        else                   word_c = '0;
      end
      MODE_CHASE:  word_c = (k == chase_pos) ? '1 : '0;
      default:     word_c = '0;
    endcase
  end

endmodule

// File: rtl/led_frame_writer.sv
// Frame-based LED driver RAM writer: waits out driver configuration, then
// every frame pulses sdbp_flag and streams one word per LED from a
// per-frame snapshot of the brightness map, mode and gain.
// Ports:
//   clk, rst_n   - system clock, async active-low reset
//   light_flat   - brightness map, pixel i at [i*PIX_W +: PIX_W]
//   mode         - 0 MAP, 1 FULL, 2 STRIPE, 3 CHASE (sampled at frame start)
//   gain         - map-mode multiplier (sampled at frame start)
//   ready        - configuration wait finished, sticky until reset
//   frame_start  - one-cycle pulse at frame cycle 0
//   sdbp_flag    - frame-sync flag, high for frame cycles 1..FLAG_LEN
//   wr_en/addr/data - driver RAM write port
module led_frame_writer
  import led_pkg::*;
#(
  parameter int unsigned N_LED      = led_pkg::N_LED,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned GAIN_W     = 8,
  parameter int unsigned INIT_CYC   = 2500,
  parameter int unsigned FRAME_CYC  = 420000,
  parameter int unsigned FLAG_LEN   = 29,
  parameter int unsigned WR_START   = 4,
  parameter int unsigned ROW_LEN    = led_pkg::ROW_LEN,
  parameter int unsigned CHASE_HOLD = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_LED*PIX_W-1:0]        light_flat,
  input  logic [1:0]                    mode,
  input  logic [GAIN_W-1:0]             gain,
  output logic                          ready,
  output logic                          frame_start,
  output logic                          sdbp_flag,
  output logic                          wr_en,
  output logic [$clog2(N_LED)-1:0]      wr_addr,
  output logic [PIX_W+GAIN_W-1:0]       wr_data
);

  localparam int unsigned AW    = $clog2(N_LED);
  localparam int unsigned DAT_W = PIX_W + GAIN_W;
  localparam int unsigned IW    = $clog2(INIT_CYC + 1);
  localparam int unsigned FW    = $clog2(FRAME_CYC);
  localparam int unsigned CW    = $clog2(ROW_LEN);
  localparam int unsigned HW    = $clog2(CHASE_HOLD + 1);

  state_e                 state;
  logic [IW-1:0]          init_cnt;
  logic [FW-1:0]          fcnt;
  logic [CW-1:0]          col;
  logic [HW-1:0]          hold_cnt;
  logic [AW-1:0]          chase_pos;

  logic [N_LED*PIX_W-1:0] snap_light;
  mode_e                  snap_mode;
  logic [GAIN_W-1:0]      snap_gain;
  logic [AW-1:0]          snap_chase;

  logic [FW-1:0]          fcnt_nxt_c;
  logic                   frame_tick_c;
  logic [AW-1:0]          idx_c;
  logic [CW-1:0]          col_c;
  logic [31:0]            pix_base_c;
  logic [PIX_W-1:0]       pix_c;
  logic [DAT_W-1:0]       word_c;
  logic                   wr_next_c;

  // Next frame-cycle index and the frame-boundary tick that loads the snapshot.
  always_comb begin
    fcnt_nxt_c   = (fcnt == FW'(FRAME_CYC - 1)) ? '0 : fcnt + FW'(1);
    frame_tick_c = (state == S_INIT) ? (init_cnt == IW'(INIT_CYC - 1))
                                     : (fcnt_nxt_c == '0);
  end

  // Index/column of the word registered on the coming edge; the pattern is
  // computed one cycle ahead so wr_data lines up with wr_addr.
  always_comb begin
    idx_c = '0;
    col_c = '0;
    if (state == S_WRITE) begin
      idx_c = wr_addr + AW'(1);
      col_c = (col == CW'(ROW_LEN - 1)) ? '0 : col + CW'(1);
    end
    pix_base_c = 32'(idx_c) * PIX_W;
    pix_c      = snap_light[pix_base_c +: PIX_W];
    wr_next_c  = ((state == S_WAIT)  && (fcnt_nxt_c == FW'(WR_START))) ||
                 ((state == S_WRITE) && (wr_addr != AW'(N_LED - 1)));
  end

  led_pattern_gen #(
    .AW      (AW),
    .PIX_W   (PIX_W),
    .GAIN_W  (GAIN_W),
    .ROW_LEN (ROW_LEN),
    .CW      (CW),
    .DAT_W   (DAT_W)
  ) u_pattern (
    .mode      (snap_mode),
    .k         (idx_c),
    .col       (col_c),
    .chase_pos (snap_chase),
    .pix       (pix_c),
    .gain      (snap_gain),
    .word_c    (word_c)
  );

  // Control FSM, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      init_cnt    <= '0;
      fcnt        <= '0;
      col         <= '0;
      ready       <= 1'b0;
      frame_start <= 1'b0;
      sdbp_flag   <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      case (state)
        S_INIT: begin
          if (frame_tick_c) begin
            state       <= S_WAIT;
            ready       <= 1'b1;
            fcnt        <= '0;
            frame_start <= 1'b1;
          end else begin
            init_cnt <= init_cnt + IW'(1);
          end
        end
        default: begin
          fcnt        <= fcnt_nxt_c;
          frame_start <= frame_tick_c;
          sdbp_flag   <= (fcnt_nxt_c >= FW'(1)) && (fcnt_nxt_c <= FW'(FLAG_LEN));
          wr_en       <= 1'b0;
          wr_addr     <= '0;
          wr_data     <= '0;
          if (wr_next_c) begin
            state   <= S_WRITE;
            wr_en   <= 1'b1;
            wr_addr <= idx_c;
            wr_data <= word_c;
            col     <= col_c;
          end else begin
            state <= S_WAIT;
          end
        end
      endcase
    end
  end

  // Per-frame snapshot and chase position; chase_pos is sampled before it
  // advances so a position is shown for CHASE_HOLD whole frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_light <= '0;
      snap_mode  <= MODE_MAP;
      snap_gain  <= '0;
      snap_chase <= '0;
      hold_cnt   <= '0;
      chase_pos  <= '0;
    end else if (frame_tick_c) begin
      snap_light <= light_flat;
      snap_mode  <= mode_e'(mode);
      snap_gain  <= gain;
      snap_chase <= chase_pos;
      if (hold_cnt == HW'(CHASE_HOLD - 1)) begin
        hold_cnt  <= '0;
        chase_pos <= (chase_pos == AW'(N_LED - 1)) ? '0 : chase_pos + AW'(1);
      end else begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

endmodule
